// File: rtl/qdiv.sv
// qdiv: sequential signed restoring divider, one quotient bit per clock, then sign fix-up.
// Define QDIV_SAT_EN for saturating divide-by-zero / overflow results instead of wrap/all-ones.
module qdiv #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         input_vld,
  input  logic [N-1:0] dividend_din,
  input  logic [N-1:0] divisor_din,
  output logic [N-1:0] quotient_dout,
  output logic [N-1:0] remainder_dout,
  output logic         dout_vld,
  output logic         div_zero,
  output logic         div_ovf,
  output logic         div_end
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic [5:0]   LAST_IT = 6'(N - 1);

  state_t       state, state_nxt;
  logic [5:0]   cnt;
  logic [N:0]   pr;        // partial remainder, one extra bit keeps the trial sign
  logic [N-1:0] dq;        // dividend magnitude shifting out, quotient bits shifting in
  logic [N-1:0] dvs_mag;
  logic [N-1:0] dvd_raw;
  logic         neg_q, neg_r, zero_f, ovf_f;

  logic [N:0]   shifted, trial;
  logic [N-1:0] dvd_abs, dvs_abs, q_fix, r_fix;
  logic         accept;

  assign accept  = (state == IDLE) && input_vld;
  assign div_end = (state == IDLE);

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (input_vld) state_nxt = CALC;
      CALC:    if (cnt == LAST_IT) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dvd_abs = dividend_din[N-1] ? -dividend_din : dividend_din;
    dvs_abs = divisor_din[N-1]  ? -divisor_din  : divisor_din;
    shifted = {pr[N-1:0], dq[N-1]};
    trial   = shifted - {1'b0, dvs_mag};

    q_fix = neg_q ? -dq : dq;
    r_fix = neg_r ? -pr[N-1:0] : pr[N-1:0];
    if (zero_f) begin
`ifdef QDIV_SAT_EN
      q_fix = neg_r ? MIN_VAL : MAX_VAL;
      r_fix = '0;
`else
      q_fix = '1;
      r_fix = dvd_raw;
`endif
    end else if (ovf_f) begin
`ifdef QDIV_SAT_EN
      q_fix = MAX_VAL;
`else
      q_fix = MIN_VAL;
`endif
      r_fix = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      pr             <= '0;
      dq             <= '0;
      dvs_mag        <= '0;
      dvd_raw        <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      zero_f         <= 1'b0;
      ovf_f          <= 1'b0;
      quotient_dout  <= '0;
      remainder_dout <= '0;
      dout_vld       <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
    end else begin
      state    <= state_nxt;
      dout_vld <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          neg_r   <= dividend_din[N-1];
          neg_q   <= dividend_din[N-1] ^ divisor_din[N-1];
          dq      <= dvd_abs;
          dvs_mag <= dvs_abs;
          dvd_raw <= dividend_din;
          pr      <= '0;
          zero_f  <= (divisor_din == '0);
          ovf_f   <= (dividend_din == MIN_VAL) && (divisor_din == '1);
          cnt     <= '0;
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (!trial[N]) begin
            pr <= trial;
            dq <= {dq[N-2:0], 1'b1};
          end else begin
            pr <= shifted;
            dq <= {dq[N-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient_dout  <= q_fix;
          remainder_dout <= r_fix;
          div_zero       <= zero_f;
          div_ovf        <= ovf_f;
          dout_vld       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
